// File: rtl/modbus_pkg.sv
// Shared Modbus CRC definitions: arbiter state encoding, requester indices
// and the reflected CRC-16/MODBUS byte update.
package modbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic REQ_RX = 1'b0;
   localparam logic REQ_TX = 1'b1;

   localparam int CRC_W = 16;
   localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
   localparam logic [CRC_W-1:0] CRC_POLY = 16'hA001;

   function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [7:0] data);
      logic [CRC_W-1:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_16.sv
// Modbus CRC-16 engine: one byte per enabled cycle into a registered
// accumulator; clear reloads the 16'hFFFF seed.
module crc_16
   import modbus_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             crc_en,
   input  logic             crc_clr,
   input  logic [7:0]       data_in,
   output logic [CRC_W-1:0] crc_out
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc_out <= CRC_INIT;
      end else if (crc_clr) begin
         crc_out <= CRC_INIT;
      end else if (crc_en) begin
         crc_out <= crc16_byte(crc_out, data_in);
      end
   end

endmodule

// File: rtl/modbus_crc_arbiter.sv
// Round-robin owner of the shared crc_16 engine for the RX checker and TX builder.
// Optional stall timeout: define MODBUS_CRC_TIMEOUT_EN.
module modbus_crc_arbiter
   import modbus_pkg::*;
#(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   output logic [1:0]       gnt,
   input  logic             s0_vld,
   input  logic [7:0]       s0_data,
   input  logic             s0_last,
   output logic             s0_rdy,
   input  logic             s1_vld,
   input  logic [7:0]       s1_data,
   input  logic             s1_last,
   output logic             s1_rdy,
   output logic             crc_done,
   output logic [CRC_W-1:0] crc_val,
   output logic             crc_owner,
   output logic [7:0]       crc_len,
   output logic             crc_abort,
   output state_t           dbg_state
);

   // Byte channels: a byte moves on a cycle where vld and rdy are both high;
   // rdy is only ever raised for the granted requester while streaming.

   state_t           state;
   logic             ptr;
   logic [7:0]       byte_cnt;
   logic [1:0]       wait_cnt;
   logic             crc_en;
   logic             crc_clr;
   logic [7:0]       data_in;
   logic [CRC_W-1:0] crc_out;

   logic             hs0, hs1, hs, hs_last, owner_req, pick, stall_to, abort_now;
   logic [7:0]       hs_data, cnt_next;

   assign hs0       = s0_vld & s0_rdy;
   assign hs1       = s1_vld & s1_rdy;
   assign hs        = hs0 | hs1;
   assign hs_data   = hs1 ? s1_data : s0_data;
   assign hs_last   = hs1 ? s1_last : s0_last;
   assign owner_req = req[crc_owner];
   assign cnt_next  = byte_cnt + 8'd1;
   assign pick      = (req[0] & req[1]) ? ptr : req[1];
   assign dbg_state = state;

`ifdef MODBUS_CRC_TIMEOUT_EN
   logic [7:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != ST_STREAM || hs) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end

   assign stall_to = !hs && (stall_cnt == 8'(TIMEOUT_CYC - 1));
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT_CYC);
   assign stall_to       = 1'b0;
`endif

   assign abort_now = (state == ST_STREAM) &&
                      (!owner_req || stall_to ||
                       (hs && !hs_last && cnt_next == 8'(MAX_LEN)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= REQ_RX;
         crc_owner <= REQ_RX;
         gnt       <= '0;
         s0_rdy    <= 1'b0;
         s1_rdy    <= 1'b0;
         crc_done  <= 1'b0;
         crc_abort <= 1'b0;
         crc_val   <= '0;
         crc_len   <= '0;
         byte_cnt  <= '0;
         wait_cnt  <= '0;
         crc_en    <= 1'b0;
         crc_clr   <= 1'b1;
         data_in   <= '0;
      end else begin
         crc_en    <= 1'b0;
         crc_clr   <= 1'b0;
         crc_done  <= 1'b0;
         crc_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  crc_owner <= pick;
                  gnt       <= pick ? 2'b10 : 2'b01;
                  crc_clr   <= 1'b1;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               byte_cnt <= '0;
               s0_rdy   <= (crc_owner == REQ_RX);
               s1_rdy   <= (crc_owner == REQ_TX);
               state    <= ST_STREAM;
            end
            ST_STREAM: begin
               if (abort_now) begin
                  crc_abort <= 1'b1;
                  gnt       <= '0;
                  s0_rdy    <= 1'b0;
                  s1_rdy    <= 1'b0;
                  ptr       <= ~crc_owner;
                  state     <= ST_IDLE;
               end else if (hs) begin
                  crc_en   <= 1'b1;
                  data_in  <= hs_data;
                  byte_cnt <= cnt_next;
                  if (hs_last) begin
                     s0_rdy   <= 1'b0;
                     s1_rdy   <= 1'b0;
                     wait_cnt <= '0;
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // Covers the enable register and the engine's output register
               // so crc_done lands four cycles after the last byte.
               wait_cnt <= wait_cnt + 2'd1;
               if (wait_cnt == 2'd2) begin
                  crc_val  <= crc_out;
                  crc_len  <= byte_cnt;
                  crc_done <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               gnt   <= '0;
               ptr   <= ~crc_owner;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   crc_16 u_crc (
      .clk     (clk),
      .rst_n   (~rst),
      .crc_en  (crc_en),
      .crc_clr (crc_clr),
      .data_in (data_in),
      .crc_out (crc_out)
   );

endmodule

// File: tb/tb_modbus_crc_arbiter.sv
// Directed bench for modbus_crc_arbiter: known Modbus frame CRCs, arbitration,
// aborts, MAX_LEN cap, stall behaviour (MODBUS_CRC_TIMEOUT_EN aware), reset.
module tb_modbus_crc_arbiter;
   import modbus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        s0_vld, s0_last, s0_rdy, s1_vld, s1_last, s1_rdy;
   logic [7:0]  s0_data, s1_data;
   logic        crc_done, crc_owner, crc_abort;
   logic [15:0] crc_val;
   logic [7:0]  crc_len;
   state_t      dbg_state;

   logic        m_req_en;
   logic [1:0]  m_req, m_gnt;
   logic        m_s0_vld, m_s0_last, m_s0_rdy, m_s1_vld, m_s1_last, m_s1_rdy;
   logic [7:0]  m_s0_data, m_s1_data;
   logic        m_crc_done, m_crc_owner, m_crc_abort;
   logic [15:0] m_crc_val;
   logic [7:0]  m_crc_len;
   state_t      m_dbg_state;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          bad_rdy = 0;
   bit          both_pulse = 0;
   logic [15:0] exp_q[$];

   localparam logic [63:0] RX_BYTES  = 64'h0000_0100_0000_0301; // 01 03 00 00 00 01
   localparam logic [63:0] TX_BYTES  = 64'h0000_0300_0100_0601; // 01 06 00 01 00 03
   localparam logic [63:0] EXC_BYTES = 64'h0000_0000_0002_8301; // 01 83 02

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   always @(negedge clk) begin
      if ((s0_rdy && !gnt[0]) || (s1_rdy && !gnt[1])) bad_rdy = 1;
      if (crc_done && crc_abort) both_pulse = 1;
   end

   assign m_req = {1'b0, m_req_en};

   modbus_crc_arbiter #(.MAX_LEN(16), .TIMEOUT_CYC(8)) u_dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .s0_vld(s0_vld), .s0_data(s0_data), .s0_last(s0_last), .s0_rdy(s0_rdy),
      .s1_vld(s1_vld), .s1_data(s1_data), .s1_last(s1_last), .s1_rdy(s1_rdy),
      .crc_done(crc_done), .crc_val(crc_val), .crc_owner(crc_owner),
      .crc_len(crc_len), .crc_abort(crc_abort), .dbg_state(dbg_state)
   );

   modbus_crc_arbiter #(.MAX_LEN(4), .TIMEOUT_CYC(255)) u_dut4 (
      .clk(clk), .rst(rst), .req(m_req), .gnt(m_gnt),
      .s0_vld(m_s0_vld), .s0_data(m_s0_data), .s0_last(m_s0_last), .s0_rdy(m_s0_rdy),
      .s1_vld(m_s1_vld), .s1_data(m_s1_data), .s1_last(m_s1_last), .s1_rdy(m_s1_rdy),
      .crc_done(m_crc_done), .crc_val(m_crc_val), .crc_owner(m_crc_owner),
      .crc_len(m_crc_len), .crc_abort(m_crc_abort), .dbg_state(m_dbg_state)
   );

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int port, input logic v, input logic [7:0] d, input logic l);
      if (port == 0) begin
         s0_vld = v; s0_data = d; s0_last = l;
      end else begin
         s1_vld = v; s1_data = d; s1_last = l;
      end
   endtask

   task automatic send(input int port, input int n, input logic [63:0] bytes, input bit with_last,
                       input int stall_at, input int stall_len, output int t_last);
      int k;
      t_last = -1;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            set_src(port, 1'b0, 8'h00, 1'b0);
            repeat (stall_len) step();
         end
         set_src(port, 1'b1, bytes[8*i +: 8], with_last && (i == n - 1));
         k = 0;
         while (((port == 0) ? s0_rdy : s1_rdy) !== 1'b1 && k < 30) begin
            step();
            k++;
         end
         checks++;
         if (k >= 30) begin
            errors++;
            $display("FAIL send_rdy port%0d byte%0d: rdy low for 30 cycles, required 1", port, i);
            set_src(port, 1'b0, 8'h00, 1'b0);
            return;
         end
         t_last = cyc;
         step();
      end
      set_src(port, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic m_send(input int n, input logic [63:0] bytes, input bit with_last, output int t_last);
      int k;
      t_last = -1;
      for (int i = 0; i < n; i++) begin
         m_s0_vld = 1'b1; m_s0_data = bytes[8*i +: 8]; m_s0_last = with_last && (i == n - 1);
         k = 0;
         while (m_s0_rdy !== 1'b1 && k < 30) begin
            step();
            k++;
         end
         checks++;
         if (k >= 30) begin
            errors++;
            $display("FAIL m_send_rdy byte%0d: rdy low for 30 cycles, required 1", i);
            m_s0_vld = 1'b0;
            return;
         end
         t_last = cyc;
         step();
      end
      m_s0_vld = 1'b0; m_s0_last = 1'b0;
   endtask

   task automatic wait_end(output bit saw_done, output bit saw_abort, output int t_evt);
      saw_done = 0; saw_abort = 0; t_evt = -1;
      for (int k = 0; k < 40 && !saw_done && !saw_abort; k++) begin
         if (crc_done === 1'b1 || crc_abort === 1'b1) begin
            saw_done = crc_done; saw_abort = crc_abort; t_evt = cyc;
         end else begin
            step();
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1; req = 2'b00; m_req_en = 1'b0;
      set_src(0, 1'b0, 8'h00, 1'b0); set_src(1, 1'b0, 8'h00, 1'b0);
      m_s0_vld = 0; m_s0_data = 0; m_s0_last = 0; m_s1_vld = 0; m_s1_data = 0; m_s1_last = 0;
      repeat (3) step();
      checks++;
      if (gnt !== 2'b00 || s0_rdy !== 1'b0 || s1_rdy !== 1'b0 || crc_done !== 1'b0 || crc_abort !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt=%b rdy=%b%b done=%b abort=%b, required all 0", gnt, s1_rdy, s0_rdy, crc_done, crc_abort);
      end
      checks++;
      if (crc_val !== 16'h0000 || crc_len !== 8'd0 || crc_owner !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_data: val=%h len=%0d owner=%b state=%0d, required 0000 0 0 IDLE", crc_val, crc_len, crc_owner, dbg_state);
      end
      checks++;
      if (m_gnt !== 2'b00 || m_crc_len !== 8'd0 || m_dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_m4: gnt=%b len=%0d state=%0d, required 00 0 IDLE", m_gnt, m_crc_len, m_dbg_state);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_both();
      int t, te, k; bit d, a; logic [15:0] exp;
      exp_q.push_back(16'hF1C0); exp_q.push_back(16'hF1C0);
      set_src(1, 1'b1, 8'h01, 1'b0);
      req = 2'b11;
      step();
      checks++;
      if (gnt !== 2'b01) begin errors++; $display("FAIL both_first_grant: gnt=%b, required 01", gnt); end
      send(0, 3, EXC_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      exp = exp_q.pop_front();
      checks++;
      if (!d || crc_val !== exp || crc_owner !== 1'b0 || crc_len !== 8'd3) begin
         errors++;
         $display("FAIL both_job0: done=%b val=%h owner=%b len=%0d, required 1 %h 0 3", d, crc_val, crc_owner, crc_len, exp);
      end
      req = 2'b10;
      k = 0;
      step();
      while (gnt !== 2'b10 && k < 10) begin step(); k++; end
      checks++;
      if (gnt !== 2'b10 || cyc != te + 2) begin
         errors++;
         $display("FAIL both_second_grant: gnt=%b at cycle %0d, required 10 at %0d", gnt, cyc, te + 2);
      end
      send(1, 3, EXC_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      exp = exp_q.pop_front();
      checks++;
      if (!d || crc_val !== exp || crc_owner !== 1'b1 || crc_len !== 8'd3) begin
         errors++;
         $display("FAIL both_job1: done=%b val=%h owner=%b len=%0d, required 1 %h 1 3", d, crc_val, crc_owner, crc_len, exp);
      end
      req = 2'b00;
      step();
      checks++;
      if (bad_rdy) begin errors++; $display("FAIL nonowner_rdy: rdy seen without grant=1, required 0"); end
   endtask

   task automatic test_single_rx();
      int t, te; bit d, a; logic [15:0] exp;
      exp_q.push_back(16'h0A84);
      req = 2'b01;
      step();
      checks++;
      if (gnt !== 2'b01 || s0_rdy !== 1'b0) begin
         errors++; $display("FAIL rx_grant_r1: gnt=%b s0_rdy=%b, required 01 0", gnt, s0_rdy);
      end
      step();
      checks++;
      if (s0_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy_r2: s0_rdy=%b, required 1", s0_rdy); end
      send(0, 6, RX_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      exp = exp_q.pop_front();
      checks++;
      if (!d || te != t + 4) begin errors++; $display("FAIL rx_done_time: done=%b at %0d, required 1 at %0d", d, te, t + 4); end
      checks++;
      if (crc_val !== exp || crc_owner !== 1'b0 || crc_len !== 8'd6 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL rx_result: val=%h owner=%b len=%0d gnt=%b, required %h 0 6 01", crc_val, crc_owner, crc_len, gnt, exp);
      end
      req = 2'b00;
      step();
      checks++;
      if (gnt !== 2'b00 || crc_done !== 1'b0) begin
         errors++; $display("FAIL rx_release: gnt=%b done=%b, required 00 0", gnt, crc_done);
      end
   endtask

   task automatic test_single_tx();
      int t, te; bit d, a; logic [15:0] exp;
      exp_q.push_back(16'h0B98);
      req = 2'b10;
      send(1, 6, TX_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      exp = exp_q.pop_front();
      checks++;
      if (!d || te != t + 4 || crc_val !== exp || crc_owner !== 1'b1 || crc_len !== 8'd6) begin
         errors++;
         $display("FAIL tx_result: done=%b t=%0d val=%h owner=%b len=%0d, required 1 %0d %h 1 6", d, te, crc_val, crc_owner, crc_len, t + 4, exp);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_abort_drop();
      int t, te; bit d, a; logic [15:0] exp;
      req = 2'b01;
      send(0, 3, 64'h0000_0000_0003_0201, 0, -1, 0, t);
      req = 2'b00;
      step();
      checks++;
      if (crc_abort !== 1'b1 || crc_done !== 1'b0 || gnt !== 2'b00) begin
         errors++; $display("FAIL drop_abort: abort=%b done=%b gnt=%b, required 1 0 00", crc_abort, crc_done, gnt);
      end
      checks++;
      if (crc_val !== 16'h0B98 || crc_len !== 8'd6) begin
         errors++; $display("FAIL drop_hold: val=%h len=%0d, required 0b98 6", crc_val, crc_len);
      end
      step();
      checks++;
      if (crc_abort !== 1'b0) begin errors++; $display("FAIL drop_pulse: abort=%b, required 0", crc_abort); end
      exp_q.push_back(16'h0A84);
      req = 2'b01;
      send(0, 6, RX_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      exp = exp_q.pop_front();
      checks++;
      if (!d || crc_val !== exp || crc_len !== 8'd6) begin
         errors++; $display("FAIL drop_next_job: done=%b val=%h len=%0d, required 1 %h 6", d, crc_val, crc_len, exp);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_max_len();
      int t, k; bit seen;
      m_req_en = 1'b1;
      m_send(4, 64'h0000_0000_0403_0201, 0, t);
      m_s0_vld = 1'b1; m_s0_data = 8'h05; m_s0_last = 1'b0;
      checks++;
      if (m_crc_abort !== 1'b1 || cyc != t + 1) begin
         errors++; $display("FAIL maxlen_abort: abort=%b at %0d, required 1 at %0d", m_crc_abort, cyc, t + 1);
      end
      checks++;
      if (m_s0_rdy !== 1'b0 || m_crc_done !== 1'b0 || m_crc_len !== 8'd0 || m_gnt !== 2'b00) begin
         errors++;
         $display("FAIL maxlen_state: rdy=%b done=%b len=%0d gnt=%b, required 0 0 0 00", m_s0_rdy, m_crc_done, m_crc_len, m_gnt);
      end
      m_req_en = 1'b0; m_s0_vld = 1'b0;
      step();
      m_req_en = 1'b1;
      m_send(3, EXC_BYTES, 1, t);
      seen = 0; k = 0;
      while (!seen && k < 20) begin
         if (m_crc_done === 1'b1) seen = 1; else begin step(); k++; end
      end
      checks++;
      if (!seen || m_crc_val !== 16'hF1C0 || m_crc_len !== 8'd3) begin
         errors++; $display("FAIL maxlen_next_job: done=%b val=%h len=%0d, required 1 f1c0 3", seen, m_crc_val, m_crc_len);
      end
      m_req_en = 1'b0;
      step();
   endtask

   task automatic test_stall();
      int t, te; bit d, a;
      req = 2'b10;
`ifdef MODBUS_CRC_TIMEOUT_EN
      send(1, 2, TX_BYTES, 0, -1, 0, t);
      wait_end(d, a, te);
      checks++;
      if (!a || d || te != t + 9 || crc_val !== 16'h0A84) begin
         errors++;
         $display("FAIL stall_timeout: abort=%b done=%b t=%0d val=%h, required 1 0 %0d 0a84", a, d, te, crc_val, t + 9);
      end
`else
      send(1, 6, TX_BYTES, 1, 2, 8, t);
      wait_end(d, a, te);
      checks++;
      if (!d || a || te != t + 4 || crc_val !== 16'h0B98 || crc_len !== 8'd6) begin
         errors++;
         $display("FAIL stall_complete: done=%b abort=%b t=%0d val=%h len=%0d, required 1 0 %0d 0b98 6", d, a, te, crc_val, crc_len, t + 4);
      end
`endif
      req = 2'b00;
      step();
   endtask

   task automatic test_back_to_back();
      int t, te, g1, k; bit d, a;
      req = 2'b01;
      step();
      g1 = cyc;
      send(0, 3, EXC_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      step();
      k = 0;
      while (gnt !== 2'b01 && k < 10) begin step(); k++; end
      checks++;
      if (gnt !== 2'b01 || cyc - g1 != 9) begin
         errors++; $display("FAIL b2b_period: gnt=%b period=%0d, required 01 9", gnt, cyc - g1);
      end
      send(0, 3, EXC_BYTES, 1, -1, 0, t);
      wait_end(d, a, te);
      checks++;
      if (!d || crc_val !== 16'hF1C0 || crc_len !== 8'd3) begin
         errors++; $display("FAIL b2b_job2: done=%b val=%h len=%0d, required 1 f1c0 3", d, crc_val, crc_len);
      end
      req = 2'b00;
      step();
   endtask

   task automatic test_reset_mid_job();
      int t, pulses;
      req = 2'b01;
      send(0, 2, RX_BYTES, 0, -1, 0, t);
      rst = 1'b1; req = 2'b00;
      step();
      checks++;
      if (gnt !== 2'b00 || s0_rdy !== 1'b0 || crc_val !== 16'h0000 || crc_len !== 8'd0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL midreset_state: gnt=%b rdy=%b val=%h len=%0d state=%0d, required 00 0 0000 0 IDLE", gnt, s0_rdy, crc_val, crc_len, dbg_state);
      end
      step();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (crc_done || crc_abort) pulses++;
         step();
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL midreset_pulse: pulses=%0d, required 0", pulses); end
   endtask

   initial begin
      test_reset();
      test_both();
      test_single_rx();
      test_single_tx();
      test_abort_drop();
      test_max_len();
      test_stall();
      test_back_to_back();
      test_reset_mid_job();
      checks++;
      if (both_pulse) begin errors++; $display("FAIL done_abort_overlap: seen=1, required 0"); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/modbus_crc_arbiter.md
# modbus_crc_arbiter

Shares the single `crc_16` engine between the two Modbus CRC users: the receive-frame checker (requester 0) and the response builder (requester 1). It grants the engine to one requester per frame and clears the CRC register. It then streams that requester's bytes into the engine through a valid/ready handshake and returns the finished 16-bit CRC with a one-cycle done pulse tagged with the owner. It sits between the frame receive/handler logic and the transmit serializer, replacing per-path CRC sequencing.

## Interface
- `MAX_LEN`, 16: maximum bytes per CRC job; range 1..255.
- `TIMEOUT_CYC`, 255: stall limit in cycles; used only with `MODBUS_CRC_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  2  per-requester job request; level, held until `crc_done`/`crc_abort`.
- `gnt`  out  2  one-hot grant; high from grant until the job ends.
- `s0_vld`, `s1_vld`  in  1  byte valid, requester 0/1.
- `s0_data`, `s1_data`  in  8  byte, requester 0/1.
- `s0_last`, `s1_last`  in  1  final byte of the job, qualified by vld.
- `s0_rdy`, `s1_rdy`  out  1  byte accepted when vld&rdy.
- `crc_done`  out  1  one-cycle pulse; `crc_val` is valid.
- `crc_val`  out  16  CRC result: engine output, low byte transmitted first.
- `crc_owner`  out  1  requester index of the current/last job.
- `crc_len`  out  8  bytes consumed by the completed job.
- `crc_abort`  out  1  one-cycle pulse; the job was terminated without a result.

## Operation
- States: IDLE, CLEAR, STREAM, WAIT, DONE.
- IDLE: when any `req` bit is set, select the owner and go to CLEAR.
  - If both requests are set, the requester not served last wins (round-robin pointer). After reset the pointer favours requester 0.
- CLEAR: assert `gnt[owner]` and drive `crc_clr`=1 for one cycle. Reset `byte_cnt`. Go to STREAM.
- STREAM: `sN_rdy` = `gnt[N]`; the non-owner's rdy stays 0.
  - On each handshake, register `crc_en`=1 and `data_in`=byte on the next cycle, and increment `byte_cnt`.
  - If the accepted byte has `last`=1, go to WAIT.
- WAIT: 2 cycles, absorbing the engine's output register. Then go to DONE.
- DONE: capture `crc_val`=`crc_out` and `crc_len`=`byte_cnt`, pulse `crc_done`, deassert `gnt`, update the round-robin pointer. Return to IDLE.
- Aborts:
  - Abort conditions, checked in STREAM:
    - owner drops `req`;
    - a handshake brings `byte_cnt` to `MAX_LEN` without `last`.
  - On abort: pulse `crc_abort`, clear `gnt`, update the pointer, go to IDLE. `crc_val` and `crc_len` are unchanged.
- `byte_cnt` is 8 bits and never wraps; `MAX_LEN` caps it.
- A non-owner `req` rising mid-job waits; it never preempts.
- `vld` without `rdy` (non-owner, or outside STREAM) is ignored; data is not consumed.

## Timing
- Reset values:
  - `gnt`=0, `s0_rdy`=`s1_rdy`=0, `crc_done`=0, `crc_abort`=0.
  - `crc_val`=0, `crc_len`=0, `crc_owner`=0.
  - State=IDLE, pointer=0, `crc_en`=0, `crc_clr`=1.
- Reset mid-job discards the job with no done/abort pulse.
- Request in IDLE at cycle R: `gnt` high at R+1 (CLEAR); rdy high at R+2.
- Last-byte accept at T: `crc_en` for that byte at T+1, engine output visible T+2, `crc_done` high at T+4, `gnt` low at T+5.
- Back-to-back jobs: the next grant is no earlier than the cycle after `crc_done`. Minimum job period is 6 + N cycles for N bytes at full rate.
- `crc_done` and `crc_abort` are never high in the same cycle.

## Configuration
- `MODBUS_CRC_TIMEOUT_EN` defined: in STREAM, a stall counter counts cycles without a handshake and resets on each handshake. When it reaches `TIMEOUT_CYC`, the job aborts as above.
- Macro undefined: no counter; STREAM waits indefinitely for the owner's bytes.

## Structure
- Shared package `modbus_pkg` holds:
  - state encoding;
  - requester indices `REQ_RX`=0, `REQ_TX`=1;
  - `CRC_W`=16.
- Sub-module: the existing `crc_16` (ports clk/rst_n/crc_en/crc_clr/data_in/crc_out), instantiated once inside. Its `rst_n` is driven by `~rst`.
- Round-robin selection stays inline; no separate arbiter module.

## Test plan
- Req0 alone streams 01 03 00 00 00 01 -> `crc_done` with `crc_val`=16'h0A84, `crc_owner`=0, `crc_len`=6, at T+4.
- Req1 streams 01 06 00 01 00 03 -> `crc_val`=16'h0B98, `crc_owner`=1.
- Req0 and req1 rise in the same cycle, both streaming 01 83 02 -> grants go 0 then 1. Both results are 16'hF1C0. The non-owner's rdy stays 0 throughout.
- Owner drops `req` after 3 bytes -> `crc_abort` pulse, no `crc_done`, `crc_val` holds its previous value. The next job's CRC is correct, proving the clear.
- `MAX_LEN`=4 with 5 bytes and no `last` -> abort on the 4th handshake.
- With `MODBUS_CRC_TIMEOUT_EN` and `TIMEOUT_CYC`=8, stall for 8 cycles mid-job -> abort. Without the macro -> the job completes after the stall.
